// File: rtl/run_ctrl.sv
// Run controller for the uRISC harness.
// Sequences the core reset, counts run cycles, watches the error channels and
// the halt flag, and holds a sticky PASS / FAIL / TIMEOUT verdict until restart.
module run_ctrl #(
  parameter int RST_CYCLES = 3,
  parameter int MAX_CYCLES = 10000,
  parameter int HALT_DRAIN = 4,
  parameter int NUM_ERR    = 2,
  parameter int CNT_W      = 32,
  localparam int IW        = (NUM_ERR > 1) ? $clog2(NUM_ERR) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_ERR-1:0] err_vec,
  input  logic [NUM_ERR-1:0] err_mask,
  input  logic               halt,
  input  logic               restart,
  output logic               rst_core,
  output logic               running,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [IW-1:0]      err_idx,
  output logic [CNT_W-1:0]   fail_cycle,
  output logic [CNT_W-1:0]   cycle_cnt
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int DW = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;

  localparam logic [RW-1:0]    RST_LAST   = RW'(RST_CYCLES - 1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'((HALT_DRAIN > 0) ? (HALT_DRAIN - 1) : 0);
  localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_SAT    = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_RESET,
    S_RUN,
    S_DRAIN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [RW-1:0]      rst_cnt;
  logic [RW-1:0]      rst_cnt_next;
  logic [DW-1:0]      drain_cnt;
  logic [DW-1:0]      drain_cnt_next;
  logic [CNT_W-1:0]   cycle_cnt_next;
  logic [CNT_W-1:0]   fail_cycle_next;
  logic [IW-1:0]      err_idx_next;
  logic [NUM_ERR-1:0] err_act;

  // Saturating increment: a halt just before the timeout limit lets the drain
  // run past MAX_CYCLES, so the counter must hold rather than wrap.
  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    return (v == CYC_SAT) ? v : v + CNT_W'(1);
  endfunction

  // Lowest set channel index; returns 0 when nothing is set.
  function automatic logic [IW-1:0] lowest_idx(input logic [NUM_ERR-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

  assign err_act = err_vec & ~err_mask;

  // Next-state, counter and failure-capture logic.
  always_comb begin
    state_next      = state;
    rst_cnt_next    = rst_cnt;
    drain_cnt_next  = drain_cnt;
    cycle_cnt_next  = cycle_cnt;
    fail_cycle_next = fail_cycle;
    err_idx_next    = err_idx;
    unique case (state)
      S_RESET: begin
        // Errors are ignored here: the core is still held in reset.
        if (rst_cnt == RST_LAST) begin
          state_next   = S_RUN;
          rst_cnt_next = '0;
        end else begin
          rst_cnt_next = rst_cnt + RW'(1);
        end
      end
      S_RUN: begin
        cycle_cnt_next = inc_sat(cycle_cnt);
        if (|err_act) begin
          state_next      = S_FAIL;
          err_idx_next    = lowest_idx(err_act);
          fail_cycle_next = cycle_cnt;
        end else if (halt) begin
          drain_cnt_next = '0;
          state_next     = (HALT_DRAIN == 0) ? S_PASS : S_DRAIN;
        end else if (cycle_cnt == CYC_LAST) begin
          state_next = S_TIMEOUT;
        end
      end
      S_DRAIN: begin
        // Late errors still fail the run; halt has already been seen.
        cycle_cnt_next = inc_sat(cycle_cnt);
        if (|err_act) begin
          state_next      = S_FAIL;
          err_idx_next    = lowest_idx(err_act);
          fail_cycle_next = cycle_cnt;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_next = S_PASS;
        end else begin
          drain_cnt_next = drain_cnt + DW'(1);
        end
      end
      S_PASS, S_FAIL, S_TIMEOUT: begin
        if (restart) begin
          state_next      = S_RESET;
          rst_cnt_next    = '0;
          drain_cnt_next  = '0;
          cycle_cnt_next  = '0;
          fail_cycle_next = '0;
          err_idx_next    = '0;
        end
      end
      default: begin
        state_next = S_RESET;
      end
    endcase
  end

  // State register plus registered status flags decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RESET;
      rst_core <= 1'b1;
      running  <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      rst_core <= (state_next == S_RESET);
      running  <= (state_next == S_RUN) || (state_next == S_DRAIN);
      done     <= (state_next == S_PASS) || (state_next == S_FAIL) ||
                  (state_next == S_TIMEOUT);
      pass     <= (state_next == S_PASS);
      fail     <= (state_next == S_FAIL);
      timeout  <= (state_next == S_TIMEOUT);
    end
  end

  // Counters and failure capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt    <= '0;
      drain_cnt  <= '0;
      cycle_cnt  <= '0;
      fail_cycle <= '0;
      err_idx    <= '0;
    end else begin
      rst_cnt    <= rst_cnt_next;
      drain_cnt  <= drain_cnt_next;
      cycle_cnt  <= cycle_cnt_next;
      fail_cycle <= fail_cycle_next;
      err_idx    <= err_idx_next;
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed scenarios with literal expectations, then a
// randomized run, all compared every cycle against a run-level model.
module tb_run_ctrl;

  localparam int RC = 3;
  localparam int MC = 100;
  localparam int HD = 4;
  localparam int NE = 2;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NE-1:0] err_vec;
  logic [NE-1:0] err_mask;
  logic          halt;
  logic          restart;
  logic          rst_core, running, done, pass, fail, timeout;
  logic [0:0]    err_idx;
  logic [CW-1:0] fail_cycle;
  logic [CW-1:0] cycle_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // Model: edges since reset release, verdict (0 none, 1 pass, 2 fail,
  // 3 timeout), edges since halt (-1 = no halt yet), captured values.
  int m_t, m_verdict, m_halt_age, m_idx, m_fc, m_cyc;

  run_ctrl #(
    .RST_CYCLES(RC), .MAX_CYCLES(MC), .HALT_DRAIN(HD), .NUM_ERR(NE), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .err_vec(err_vec), .err_mask(err_mask), .halt(halt),
    .restart(restart), .rst_core(rst_core), .running(running), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout), .err_idx(err_idx),
    .fail_cycle(fail_cycle), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_t = 0; m_verdict = 0; m_halt_age = -1; m_idx = 0; m_fc = 0; m_cyc = 0;
  endtask

  // One clock edge of the run-level rules.
  task automatic model_step();
    logic [NE-1:0] act;
    int pre;
    if (rst) begin
      model_clear();
      return;
    end
    act = err_vec & ~err_mask;
    if (m_verdict != 0) begin
      if (restart) model_clear();
    end else if (m_t < RC) begin
      m_t++;
    end else begin
      pre = m_cyc;
      m_cyc = m_cyc + 1;
      if (act != 0) begin
        m_verdict = 2;
        m_fc = pre;
        m_idx = act[0] ? 0 : 1;
      end else if (m_halt_age < 0) begin
        if (halt) begin
          if (HD == 0) m_verdict = 1;
          else m_halt_age = 0;
        end else if (pre == MC - 1) begin
          m_verdict = 3;
        end
      end else begin
        m_halt_age++;
        if (m_halt_age == HD) m_verdict = 1;
      end
    end
  endtask

  // Advance one clock; returns 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (!(m_verdict == 0 && m_t >= RC && m_cyc == target) && n < 400) begin
      cycle();
      n++;
    end
    tests++;
    if (n >= 400) begin
      fails++;
      $display("FAIL run_to: cycle_cnt %0d never reached, model at %0d", target, m_cyc);
    end
  endtask

  task automatic run_done();
    int n = 0;
    while (m_verdict == 0 && n < 400) begin
      cycle();
      n++;
    end
    tests++;
    if (n >= 400) begin
      fails++;
      $display("FAIL run_done: no verdict within bound");
    end
  endtask

  task automatic restart_seq();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    check("restart_rst_core", 32'(rst_core), 1);
    check("restart_cnt_clr", cycle_cnt, 0);
    check("restart_done_clr", 32'(done), 0);
    cycle();
    cycle();
    check("restart_rst_core_3rd", 32'(rst_core), 1);
    cycle();
    check("restart_running", 32'(running), 1);
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_rc, e_run, e_done, e_pass, e_fail, e_to;
      e_rc   = (m_verdict == 0) && (m_t < RC);
      e_run  = (m_verdict == 0) && (m_t >= RC);
      e_done = (m_verdict != 0);
      e_pass = (m_verdict == 1);
      e_fail = (m_verdict == 2);
      e_to   = (m_verdict == 3);
      tests++;
      if (rst_core !== e_rc || running !== e_run || done !== e_done ||
          pass !== e_pass || fail !== e_fail || timeout !== e_to ||
          32'(err_idx) !== 32'(m_idx) || fail_cycle !== 32'(m_fc) ||
          cycle_cnt !== 32'(m_cyc)) begin
        fails++;
        $display("FAIL model_cmp t=%0t got rc=%b run=%b done=%b p=%b f=%b to=%b idx=%0d fc=%0d cyc=%0d required rc=%b run=%b done=%b p=%b f=%b to=%b idx=%0d fc=%0d cyc=%0d",
                 $time, rst_core, running, done, pass, fail, timeout, err_idx, fail_cycle,
                 cycle_cnt, e_rc, e_run, e_done, e_pass, e_fail, e_to, m_idx, m_fc, m_cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; err_vec = '0; err_mask = '0; halt = 1'b0; restart = 1'b0;
    model_clear();
    chk_en = 1;
    cycle();
    cycle();
    check("reset_rst_core", 32'(rst_core), 1);
    check("reset_running", 32'(running), 0);
    check("reset_done", 32'(done), 0);
    check("reset_cycle_cnt", cycle_cnt, 0);

    // T1: reset sequence length and counting start
    rst = 1'b0;
    cycle();
    check("t1_rst_core_1", 32'(rst_core), 1);
    cycle();
    check("t1_rst_core_2", 32'(rst_core), 1);
    cycle();
    check("t1_rst_core_drop", 32'(rst_core), 0);
    check("t1_running", 32'(running), 1);
    check("t1_cnt0", cycle_cnt, 0);
    cycle();
    check("t1_cnt1", cycle_cnt, 1);

    // T2: halt at 50, drain 4, pass with cycle_cnt frozen at 55
    run_to(50);
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    check("t2_drain_running", 32'(running), 1);
    check("t2_cnt51", cycle_cnt, 51);
    cycle(); cycle(); cycle();
    check("t2_not_yet_pass", 32'(pass), 0);
    cycle();
    check("t2_pass", 32'(pass), 1);
    check("t2_cnt55", cycle_cnt, 55);
    halt = 1'b1; err_vec = 2'b11;
    cycle(); cycle();
    halt = 1'b0; err_vec = 2'b00;
    check("t2_sticky_pass", 32'(pass), 1);
    check("t2_frozen", cycle_cnt, 55);
    restart_seq();

    // T3: error on channel 1 at cycle 20, then the same with it masked
    run_to(20);
    err_vec = 2'b10;
    cycle();
    err_vec = 2'b00;
    check("t3_fail", 32'(fail), 1);
    check("t3_err_idx", 32'(err_idx), 1);
    check("t3_fail_cycle", fail_cycle, 20);
    restart_seq();
    check("t3_idx_cleared", 32'(err_idx), 0);
    err_mask = 2'b10;
    run_to(20);
    err_vec = 2'b10;
    cycle();
    err_vec = 2'b00;
    check("t3_masked_no_fail", 32'(fail), 0);
    check("t3_masked_running", 32'(running), 1);
    err_mask = 2'b00;

    // T4: halt and error together; error during drain
    run_to(30);
    halt = 1'b1; err_vec = 2'b01;
    cycle();
    halt = 1'b0; err_vec = 2'b00;
    check("t4_fail", 32'(fail), 1);
    check("t4_err_idx", 32'(err_idx), 0);
    check("t4_fail_cycle", fail_cycle, 30);
    restart_seq();
    run_to(10);
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    cycle();
    err_vec = 2'b01;
    cycle();
    err_vec = 2'b00;
    check("t4_drain_fail", 32'(fail), 1);
    check("t4_drain_fail_cycle", fail_cycle, 12);
    restart_seq();

    // T5: timeout with no halt
    run_done();
    check("t5_timeout", 32'(timeout), 1);
    check("t5_cnt", cycle_cnt, MC);
    check("t5_pass_low", 32'(pass), 0);
    restart_seq();

    // T6: async reset mid-drain
    run_to(40);
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    model_clear();
    check("t6_rst_core", 32'(rst_core), 1);
    check("t6_running", 32'(running), 0);
    check("t6_pass", 32'(pass), 0);
    check("t6_cnt", cycle_cnt, 0);
    check("t6_fail_cycle", fail_cycle, 0);
    cycle();
    rst = 1'b0;
    cycle(); cycle(); cycle();
    check("t6_rerun_running", 32'(running), 1);
    check("t6_rerun_cnt", cycle_cnt, 0);

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      halt    = ($urandom_range(0, 119) == 0);
      err_vec = ($urandom_range(0, 199) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 39) == 0) err_mask = 2'($urandom_range(0, 3));
      restart = ((m_verdict != 0) && ($urandom_range(0, 3) == 0)) ||
                ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 799) == 0) begin
        rst = 1'b1;
        #1;
        model_clear();
        cycle();
        rst = 1'b0;
      end
      cycle();
    end
    halt = 1'b0; err_vec = '0; restart = 1'b0;
    cycle();
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
